data_path: RTL and testbench
============================

Name: data_path

Overview:
- Datapath for the K&S multicycle processor.
- Driven cycle-by-cycle by the control unit's strobes: branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, operation, flags_reg_enable.
- Returns to the control unit: the decoded instruction and the registered ALU flags.
- Holds PC, IR, a 4x16 register file, the ALU and the flags register. Fronts the single-port program/data RAM.

Parameters:
- DATA_W, 16, register/ALU/RAM data width. The ISA encoding below is defined only for 16.
- ADDR_W, 5, RAM address width and PC width. The ISA encoding below is defined only for 5.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- branch  in  1  with pc_enable: PC loads branch target instead of PC+1
- pc_enable  in  1  PC update strobe
- ir_enable  in  1  IR load strobe, loads data_in
- write_reg_enable  in  1  register file write strobe
- addr_sel  in  1  1: ram_addr=PC; 0: ram_addr=IR[4:0]
- c_sel  in  1  register write source. 0: ALU result; 1: data_in
- operation  in  2  ALU op. 00 OR, 01 ADD, 10 SUB, 11 AND
- flags_reg_enable  in  1  flags register load strobe
- data_in  in  DATA_W  RAM read data (asynchronous read of ram_addr)
- ram_addr  out  ADDR_W  RAM address, combinational
- data_out  out  DATA_W  RAM write data, combinational = R[IR[6:5]]
- decoded_instruction  out  decoded_instruction_type  combinational decode of IR
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags

Behaviour:
- Reset:
  - Reset is rst_n, synchronous, active-low; clock is clk.
  - On reset: PC=0, IR=0x0000, R0..R3=0, all flags=0. Hence decoded_instruction=I_NOP.
  - Reset overrides every enable in the same cycle. Reset mid-instruction discards all in-flight effects.
- Decode, from IR[15:8]:
  - 0x00 I_NOP, 0x01 I_BRANCH, 0x02 I_BZERO, 0x03 I_BNZERO, 0x04 I_BNEG, 0x05 I_BNNEG
  - 0x81 I_LOAD, 0x82 I_STORE, 0x91 I_MOVE
  - 0xA1 I_ADD, 0xA2 I_SUB, 0xA3 I_AND, 0xA4 I_OR
  - 0xFF I_HALT
  - Any other value decodes to I_NOP.
- Fields:
  - ALU/MOVE: C=IR[5:4] destination, A=IR[3:2], B=IR[1:0].
  - LOAD/STORE: register IR[6:5], address IR[4:0].
  - Branch target: IR[4:0].
- PC:
  - On pc_enable: PC <= branch ? IR[4:0] : PC+1. Wraps 31->0.
  - pc_enable=0: PC holds, branch ignored.
- IR: on ir_enable, IR <= data_in. Concurrent ir_enable and pc_enable: IR captures word at old PC and PC advances; both are legal.
- ALU, combinational, operands a=R[A], b=R[B]:
  - For I_MOVE, b is forced to 0, so OR yields R[A].
  - ADD: a+b over 17 bits. unsigned_overflow = carry out. signed_overflow = (a[15]==b[15]) && (res[15]!=a[15]).
  - SUB: a-b. unsigned_overflow = borrow (a<b unsigned). signed_overflow = (a[15]!=b[15]) && (res[15]!=a[15]).
  - AND/OR: both overflow flags 0.
  - zero = (res==0). neg = res[15].
- Flags: loaded together on flags_reg_enable, otherwise hold. One-cycle latency from ALU to zero_op/neg_op.
- Register write:
  - On write_reg_enable: R[dest] <= c_sel ? data_in : ALU result.
  - dest = IR[6:5] when decoded is I_LOAD, else IR[5:4].
  - No read bypass: a same-cycle read sees the old value.
  - All 4 registers are general purpose; R0 is not hardwired.
- Write and flags in the same cycle both use the same ALU result.
- ram_addr and data_out change combinationally with addr_sel, IR and registers. No internal state machine: sequencing is owned entirely by the control unit.

Test Plan:
- Reset then hold: rst_n=0 for 1 cycle with all enables=1 -> PC=0, IR=0, decoded_instruction=I_NOP, flags=0, registers=0.
- Fetch/advance: addr_sel=1, data_in=0xA11B, ir_enable=1 and pc_enable=1 in the same cycle -> IR=0xA11B, decoded=I_ADD, PC=1, ram_addr=1.
- ADD overflow:
  - Setup: R2=0x7FFF, R3=0x0001, IR=0xA11B (C=1, A=2, B=3).
  - Stimulus: operation=01, flags_reg_enable=1, write_reg_enable=1, c_sel=0.
  - Expected: R1=0x8000, neg=1, zero=0, signed_overflow=1, unsigned_overflow=0.
- SUB zero/borrow:
  - R2=R3=0x0005, SUB -> R1=0, zero=1.
  - R2=0x0001, R3=0x0002, SUB -> R1=0xFFFF, unsigned_overflow=1, neg=1.
- Load/store:
  - IR=0x8147 (LOAD R2, addr 7), addr_sel=0 -> ram_addr=7. data_in=0x1234, c_sel=1, write_reg_enable=1 -> R2=0x1234.
  - IR=0x8247 (STORE R2, addr 7) -> data_out=0x1234, ram_addr=7.
- Branch/wrap:
  - IR=0x0115, branch=1, pc_enable=1 -> PC=0x15.
  - PC=31, branch=0, pc_enable=1 -> PC=0.
  - IR=0x7700 -> decoded=I_NOP.

Source files
------------

// File: rtl/data_path.sv
// K&S multicycle datapath: PC, IR, 4x16 register file, ALU and flags, fronting
// the single-port program/data RAM. All sequencing comes from the control unit.
package data_path_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG,
    I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
  } decoded_instruction_type;
endpackage

module data_path
  import data_path_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  input  logic [DATA_W-1:0]       data_in,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow
);
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_rf [4];
  logic              r_zero, r_neg, r_uov, r_sov;

  logic [1:0]        w_a_idx, w_b_idx, w_dst;
  logic [DATA_W-1:0] w_a, w_b, w_res;
  logic [DATA_W:0]   w_sum;
  logic              w_uov, w_sov;
  logic              w_unused;

  always_comb begin
    case (r_ir[15:8])
      8'h01:   decoded_instruction = I_BRANCH;
      8'h02:   decoded_instruction = I_BZERO;
      8'h03:   decoded_instruction = I_BNZERO;
      8'h04:   decoded_instruction = I_BNEG;
      8'h05:   decoded_instruction = I_BNNEG;
      8'h81:   decoded_instruction = I_LOAD;
      8'h82:   decoded_instruction = I_STORE;
      8'h91:   decoded_instruction = I_MOVE;
      8'hA1:   decoded_instruction = I_ADD;
      8'hA2:   decoded_instruction = I_SUB;
      8'hA3:   decoded_instruction = I_AND;
      8'hA4:   decoded_instruction = I_OR;
      8'hFF:   decoded_instruction = I_HALT;
      default: decoded_instruction = I_NOP;
    endcase
  end

  // IR[7] is not part of any field in this ISA.
  assign w_unused = r_ir[7];

  assign w_a_idx = r_ir[3:2];
  assign w_b_idx = r_ir[1:0];
  // LOAD carries its register in [6:5]; ALU/MOVE destinations live in [5:4].
  assign w_dst   = (decoded_instruction == I_LOAD) ? r_ir[6:5] : r_ir[5:4];

  assign w_a = r_rf[w_a_idx];
  // MOVE is OR with a zero second operand, so the result is R[A].
  assign w_b = (decoded_instruction == I_MOVE) ? '0 : r_rf[w_b_idx];

  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_uov = 1'b0;
    w_sov = 1'b0;
    case (operation)
      2'b00: w_res = w_a | w_b;
      2'b01: begin
        w_sum = {1'b0, w_a} + {1'b0, w_b};
        w_res = w_sum[DATA_W-1:0];
        w_uov = w_sum[DATA_W];
        w_sov = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_res[DATA_W-1] != w_a[DATA_W-1]);
      end
      2'b10: begin
        // Top bit of the widened difference is the borrow (a < b unsigned).
        w_sum = {1'b0, w_a} - {1'b0, w_b};
        w_res = w_sum[DATA_W-1:0];
        w_uov = w_sum[DATA_W];
        w_sov = (w_a[DATA_W-1] != w_b[DATA_W-1]) && (w_res[DATA_W-1] != w_a[DATA_W-1]);
      end
      default: w_res = w_a & w_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc   <= '0;
      r_ir   <= '0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_uov  <= 1'b0;
      r_sov  <= 1'b0;
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
    end else begin
      if (pc_enable)
        r_pc <= branch ? r_ir[ADDR_W-1:0] : r_pc + ADDR_W'(1);
      if (ir_enable)
        r_ir <= data_in;
      if (write_reg_enable)
        r_rf[w_dst] <= c_sel ? data_in : w_res;
      if (flags_reg_enable) begin
        r_zero <= (w_res == '0);
        r_neg  <= w_res[DATA_W-1];
        r_uov  <= w_uov;
        r_sov  <= w_sov;
      end
    end
  end

  assign ram_addr          = addr_sel ? r_pc : r_ir[ADDR_W-1:0];
  assign data_out          = r_rf[r_ir[6:5]];
  assign zero_op           = r_zero;
  assign neg_op            = r_neg;
  assign unsigned_overflow = r_uov;
  assign signed_overflow   = r_sov;
endmodule

// File: tb/tb_data_path.sv
// Table-driven bench for data_path: each row drives one cycle of control strobes
// and queues the outputs expected right after that edge.
module tb_data_path;
  import data_path_pkg::*;

  logic clk = 1'b0;
  logic rst_n, branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable;
  logic [1:0]  operation;
  logic [15:0] data_in;
  logic [4:0]  ram_addr;
  logic [15:0] data_out;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;

  data_path dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .write_reg_enable(write_reg_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .flags_reg_enable(flags_reg_enable), .data_in(data_in),
    .ram_addr(ram_addr), .data_out(data_out), .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow)
  );

  always #5 clk = ~clk;

  // control bits: {rst_n, branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable}
  localparam logic [7:0] R = 8'h80, BR = 8'h40, PC = 8'h20, IR = 8'h10,
                         WE = 8'h08, AS = 8'h04, CS = 8'h02, FE = 8'h01;
  localparam logic [1:0] OR_ = 2'b00, ADD = 2'b01, SUB = 2'b10, AND_ = 2'b11;

  typedef struct {
    logic [7:0]  ctl;
    logic [1:0]  op;
    logic [15:0] din;
    logic [4:0]  e_addr;
    logic [15:0] e_dout;
    decoded_instruction_type e_dec;
    logic [3:0]  e_flg;   // {zero, neg, unsigned_ovf, signed_ovf}
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t V(input logic [7:0] c, input logic [1:0] op, input logic [15:0] din,
                             input logic [4:0] a, input logic [15:0] d,
                             input decoded_instruction_type dec, input logic [3:0] f);
    vec_t v;
    v.ctl = c; v.op = op; v.din = din; v.e_addr = a; v.e_dout = d; v.e_dec = dec; v.e_flg = f;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0h want=%0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {rst_n, branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable} = v.ctl;
    operation = v.op;
    data_in   = v.din;
  endtask

  initial begin
    vec_t v;
    {rst_n, branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable} = '0;
    operation = '0;
    data_in   = '0;

    // reset with every enable asserted
    vecs.push_back(V(BR|PC|IR|WE|AS|CS|FE, ADD, 16'hFFFF, 0, 16'h0000, I_NOP, 4'b0000));
    // fetch + advance together
    vecs.push_back(V(R|IR|PC|AS, OR_, 16'hA11B, 1, 16'h0000, I_ADD, 4'b0000));
    // R2=7FFF, R3=0001 through LOAD with c_sel=1
    vecs.push_back(V(R|IR|AS, OR_, 16'h8140, 1, 16'h0000, I_LOAD, 4'b0000));
    vecs.push_back(V(R|WE|CS, OR_, 16'h7FFF, 0, 16'h7FFF, I_LOAD, 4'b0000));
    vecs.push_back(V(R|IR,    OR_, 16'h8160, 0, 16'h0000, I_LOAD, 4'b0000));
    vecs.push_back(V(R|WE|CS, OR_, 16'h0001, 0, 16'h0001, I_LOAD, 4'b0000));
    // ADD R1=R2+R3 -> 8000, neg + signed overflow
    vecs.push_back(V(R|IR,    OR_, 16'hA11B, 27, 16'h0000, I_ADD, 4'b0000));
    vecs.push_back(V(R|WE|FE, ADD, 16'h0000, 27, 16'h0000, I_ADD, 4'b0101));
    vecs.push_back(V(R|IR,    OR_, 16'h8220, 0, 16'h8000, I_STORE, 4'b0101));
    // SUB 5-5 -> zero
    vecs.push_back(V(R|IR,    OR_, 16'h8140, 0, 16'h7FFF, I_LOAD, 4'b0101));
    vecs.push_back(V(R|WE|CS, OR_, 16'h0005, 0, 16'h0005, I_LOAD, 4'b0101));
    vecs.push_back(V(R|IR,    OR_, 16'h8160, 0, 16'h0001, I_LOAD, 4'b0101));
    vecs.push_back(V(R|WE|CS, OR_, 16'h0005, 0, 16'h0005, I_LOAD, 4'b0101));
    vecs.push_back(V(R|IR,    OR_, 16'hA21B, 27, 16'h0000, I_SUB, 4'b0101));
    vecs.push_back(V(R|WE|FE, SUB, 16'h0000, 27, 16'h0000, I_SUB, 4'b1000));
    vecs.push_back(V(R|IR,    OR_, 16'h8220, 0, 16'h0000, I_STORE, 4'b1000));
    // SUB 1-2 -> FFFF, borrow, neg
    vecs.push_back(V(R|IR,    OR_, 16'h8140, 0, 16'h0005, I_LOAD, 4'b1000));
    vecs.push_back(V(R|WE|CS, OR_, 16'h0001, 0, 16'h0001, I_LOAD, 4'b1000));
    vecs.push_back(V(R|IR,    OR_, 16'h8160, 0, 16'h0005, I_LOAD, 4'b1000));
    vecs.push_back(V(R|WE|CS, OR_, 16'h0002, 0, 16'h0002, I_LOAD, 4'b1000));
    vecs.push_back(V(R|IR,    OR_, 16'hA21B, 27, 16'h0000, I_SUB, 4'b1000));
    vecs.push_back(V(R|WE|FE, SUB, 16'h0000, 27, 16'h0000, I_SUB, 4'b0110));
    vecs.push_back(V(R|IR,    OR_, 16'h8220, 0, 16'hFFFF, I_STORE, 4'b0110));
    // MOVE R0<=R2 with B=R3 (=2) forced to zero: result 1, not 3
    vecs.push_back(V(R|IR,    OR_, 16'h910B, 11, 16'h0000, I_MOVE, 4'b0110));
    vecs.push_back(V(R|WE|FE, OR_, 16'h0000, 11, 16'h0001, I_MOVE, 4'b0000));
    // AND 1&2 -> zero, then flags hold when flags_reg_enable=0
    vecs.push_back(V(R|IR,    OR_, 16'hA31B, 27, 16'h0001, I_AND, 4'b0000));
    vecs.push_back(V(R|WE|FE, AND_, 16'h0000, 27, 16'h0001, I_AND, 4'b1000));
    vecs.push_back(V(R,       ADD, 16'h0000, 27, 16'h0001, I_AND, 4'b1000));
    // ADD FFFF+1 -> zero + carry; SUB 8000-1 -> signed overflow
    vecs.push_back(V(R|IR,    OR_, 16'h8140, 0, 16'h0001, I_LOAD, 4'b1000));
    vecs.push_back(V(R|WE|CS, OR_, 16'hFFFF, 0, 16'hFFFF, I_LOAD, 4'b1000));
    vecs.push_back(V(R|IR,    OR_, 16'h8160, 0, 16'h0002, I_LOAD, 4'b1000));
    vecs.push_back(V(R|WE|CS, OR_, 16'h0001, 0, 16'h0001, I_LOAD, 4'b1000));
    vecs.push_back(V(R|IR,    OR_, 16'hA11B, 27, 16'h0001, I_ADD, 4'b1000));
    vecs.push_back(V(R|WE|FE, ADD, 16'h0000, 27, 16'h0001, I_ADD, 4'b1010));
    vecs.push_back(V(R|IR,    OR_, 16'h8140, 0, 16'hFFFF, I_LOAD, 4'b1010));
    vecs.push_back(V(R|WE|CS, OR_, 16'h8000, 0, 16'h8000, I_LOAD, 4'b1010));
    vecs.push_back(V(R|IR,    OR_, 16'hA21B, 27, 16'h0001, I_SUB, 4'b1010));
    vecs.push_back(V(R|WE|FE, SUB, 16'h0000, 27, 16'h0001, I_SUB, 4'b0001));
    vecs.push_back(V(R|IR,    OR_, 16'h8220, 0, 16'h7FFF, I_STORE, 4'b0001));
    // LOAD R2 from 7, STORE R2 to 7
    vecs.push_back(V(R|IR,    OR_, 16'h8147, 7, 16'h8000, I_LOAD, 4'b0001));
    vecs.push_back(V(R|WE|CS, OR_, 16'h1234, 7, 16'h1234, I_LOAD, 4'b0001));
    vecs.push_back(V(R|IR,    OR_, 16'h8247, 7, 16'h1234, I_STORE, 4'b0001));
    // branch, branch ignored without pc_enable, wrap 31->0
    vecs.push_back(V(R|IR|AS,    OR_, 16'h0115, 1, 16'h0001, I_BRANCH, 4'b0001));
    vecs.push_back(V(R|BR|PC|AS, OR_, 16'h0000, 21, 16'h0001, I_BRANCH, 4'b0001));
    vecs.push_back(V(R|BR|AS,    OR_, 16'h0000, 21, 16'h0001, I_BRANCH, 4'b0001));
    vecs.push_back(V(R|PC|IR|AS, OR_, 16'h011F, 22, 16'h0001, I_BRANCH, 4'b0001));
    vecs.push_back(V(R|BR|PC|AS, OR_, 16'h0000, 31, 16'h0001, I_BRANCH, 4'b0001));
    vecs.push_back(V(R|PC|AS,    OR_, 16'h0000, 0, 16'h0001, I_BRANCH, 4'b0001));
    // remaining decodes, including unlisted opcodes
    vecs.push_back(V(R|IR|AS, OR_, 16'h7700, 0, 16'h0001, I_NOP, 4'b0001));
    vecs.push_back(V(R|IR|AS, OR_, 16'hFF00, 0, 16'h0001, I_HALT, 4'b0001));
    vecs.push_back(V(R|IR|AS, OR_, 16'h0200, 0, 16'h0001, I_BZERO, 4'b0001));
    vecs.push_back(V(R|IR|AS, OR_, 16'h0300, 0, 16'h0001, I_BNZERO, 4'b0001));
    vecs.push_back(V(R|IR|AS, OR_, 16'h0400, 0, 16'h0001, I_BNEG, 4'b0001));
    vecs.push_back(V(R|IR|AS, OR_, 16'h0500, 0, 16'h0001, I_BNNEG, 4'b0001));
    vecs.push_back(V(R|IR|AS, OR_, 16'h0600, 0, 16'h0001, I_NOP, 4'b0001));
    vecs.push_back(V(R|IR|AS, OR_, 16'hA400, 0, 16'h0001, I_OR, 4'b0001));
    vecs.push_back(V(R|IR|AS, OR_, 16'h8000, 0, 16'h0001, I_NOP, 4'b0001));
    // mid-instruction reset wipes everything, then view R1..R3
    vecs.push_back(V(BR|PC|IR|WE|AS|CS|FE, ADD, 16'hFFFF, 0, 16'h0000, I_NOP, 4'b0000));
    vecs.push_back(V(R|IR|AS, OR_, 16'h8220, 0, 16'h0000, I_STORE, 4'b0000));
    vecs.push_back(V(R|IR|AS, OR_, 16'h8240, 0, 16'h0000, I_STORE, 4'b0000));
    vecs.push_back(V(R|IR|AS, OR_, 16'h8260, 0, 16'h0000, I_STORE, 4'b0000));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", i, 1, 0);
      end else begin
        v = sb.pop_front();
        chk("ram_addr", i, 32'(ram_addr), 32'(v.e_addr));
        chk("data_out", i, 32'(data_out), 32'(v.e_dout));
        chk("decoded", i, 32'(decoded_instruction), 32'(v.e_dec));
        chk("flags", i, 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'(v.e_flg));
      end
    end

    // ram_addr follows addr_sel combinationally; IR holds with ir_enable low
    @(negedge clk);
    drive(V(R|IR|AS, OR_, 16'h8249, 0, 0, I_NOP, 0));
    @(posedge clk);
    #1;
    addr_sel = 1'b0;
    ir_enable = 1'b0;
    data_in = 16'h0000;
    #1;
    chk("asel0_addr", 100, 32'(ram_addr), 32'd9);
    addr_sel = 1'b1;
    #1;
    chk("asel1_addr", 101, 32'(ram_addr), 32'd0);
    @(posedge clk);
    #1;
    chk("ir_hold", 102, 32'(decoded_instruction), 32'(I_STORE));
    chk("ir_hold_addr", 103, 32'(ram_addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
